// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl: fixed 8-step instruction sequencer with strobes, halt, error and cycle counters.
// Define EXEC_SEQ_INSTCNT_EN to build the retired-instruction counter; otherwise inst_cnt is 0.
module exec_seq_ctrl #(
    parameter int CntWidth = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_wr_reg,
    input  logic                inst_load,
    input  logic                inst_store,
    input  logic                inst_halt,
    output logic                IM_enable,
    output logic                IM_read,
    output logic                IM_write,
    output logic                IR_load,
    output logic                alu_en,
    output logic                DM_enable,
    output logic                DM_read,
    output logic                DM_write,
    output logic                RF_write,
    output logic                PC_en,
    output logic [2:0]          step,
    output logic                halted,
    output logic                ctrl_err,
    output logic [CntWidth-1:0] cycle_cnt,
    output logic [CntWidth-1:0] inst_cnt
);
    localparam logic [2:0] FETCH      = 3'd0;
    localparam logic [2:0] FETCH_WAIT = 3'd1;
    localparam logic [2:0] IR         = 3'd2;
    localparam logic [2:0] DECODE     = 3'd3;
    localparam logic [2:0] EXEC       = 3'd4;
    localparam logic [2:0] MEM        = 3'd5;
    localparam logic [2:0] MEM2       = 3'd6;
    localparam logic [2:0] RETIRE     = 3'd7;

    logic c_wr, c_load, c_store, c_halt, c_ill;
    logic live, run, ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= FETCH;
            halted    <= 1'b0;
            ctrl_err  <= 1'b0;
            cycle_cnt <= '0;
            c_wr      <= 1'b0;
            c_load    <= 1'b0;
            c_store   <= 1'b0;
            c_halt    <= 1'b0;
            c_ill     <= 1'b0;
        end else if (!halted) begin
            cycle_cnt <= cycle_cnt + CntWidth'(1);
            if (step == RETIRE && c_halt)
                halted <= 1'b1;
            else
                step <= step + 3'd1;
            if (step == DECODE) begin
                c_wr     <= inst_wr_reg;
                c_load   <= inst_load;
                c_store  <= inst_store;
                c_halt   <= inst_halt;
                c_ill    <= inst_load & inst_store;
                ctrl_err <= ctrl_err | (inst_load & inst_store);
            end
        end
    end

`ifdef EXEC_SEQ_INSTCNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            inst_cnt <= '0;
        else if (!halted && !c_halt && step == RETIRE)
            inst_cnt <= inst_cnt + CntWidth'(1);
    end
`else
    assign inst_cnt = '0;
`endif

    // Strobes are masked while reset is held so a write in flight never lands.
    always_comb begin
        live      = !reset && !halted;
        run       = live && !c_halt;
        ok        = run && !c_ill;
        IM_enable = live && (step == FETCH || step == FETCH_WAIT);
        IM_read   = IM_enable;
        IM_write  = 1'b0;
        IR_load   = live && step == IR;
        alu_en    = run && step == EXEC;
        DM_enable = ok && ((step == MEM && (c_load || c_store)) || (step == MEM2 && c_load));
        DM_read   = ok && c_load && (step == MEM || step == MEM2);
        DM_write  = ok && c_store && step == MEM;
        RF_write  = ok && c_wr && (c_load ? step == RETIRE : step == MEM2);
        PC_en     = run && step == RETIRE;
    end
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// tb_exec_seq_ctrl: directed frame-by-frame checks of strobe timing, error, halt and reset.
module tb_exec_seq_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic inst_wr_reg = 1'b0, inst_load = 1'b0, inst_store = 1'b0, inst_halt = 1'b0;
    logic IM_enable, IM_read, IM_write, IR_load, alu_en, DM_enable, DM_read, DM_write, RF_write, PC_en;
    logic [2:0] step;
    logic halted, ctrl_err;
    logic [127:0] cycle_cnt, inst_cnt, icx;
    logic [7:0] im, ir, alu, de, dr, dw, rf, pc;
    int pass_cnt = 0, fail_cnt = 0, total = 0;

    exec_seq_ctrl #(.CntWidth(128)) dut (
        .clk(clk), .reset(reset), .inst_wr_reg(inst_wr_reg), .inst_load(inst_load),
        .inst_store(inst_store), .inst_halt(inst_halt), .IM_enable(IM_enable), .IM_read(IM_read),
        .IM_write(IM_write), .IR_load(IR_load), .alu_en(alu_en), .DM_enable(DM_enable),
        .DM_read(DM_read), .DM_write(DM_write), .RF_write(RF_write), .PC_en(PC_en), .step(step),
        .halted(halted), .ctrl_err(ctrl_err), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    wire [9:0] strb = {IM_enable, IM_read, IM_write, IR_load, alu_en, DM_enable, DM_read, DM_write, RF_write, PC_en};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Class inputs are inverted after the decode edge to prove they are latched.
    task automatic frame(input logic wr, input logic ld, input logic st, input logic hl);
        {inst_wr_reg, inst_load, inst_store, inst_halt} = {wr, ld, st, hl};
        for (int s = 0; s < 8; s++) begin
            chk("step", {125'd0, step}, s);
            im[s] = IM_enable & IM_read; ir[s] = IR_load; alu[s] = alu_en; de[s] = DM_enable;
            dr[s] = DM_read; dw[s] = DM_write; rf[s] = RF_write; pc[s] = PC_en;
            if (s == 4) {inst_wr_reg, inst_load, inst_store, inst_halt} = ~{wr, ld, st, hl};
            @(posedge clk); #1;
        end
        {inst_wr_reg, inst_load, inst_store, inst_halt} = 4'b0;
    endtask

    initial begin
`ifdef EXEC_SEQ_INSTCNT_EN
        icx = 128'd21;
`else
        icx = 128'd0;
`endif
        repeat (2) @(posedge clk); #1;
        chk("rst_strb", strb, 0);
        chk("rst_step", step, 0);
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_flags", {halted, ctrl_err}, 0);
        chk("rst_icnt", inst_cnt, 0);
        reset = 1'b0; #1;
        chk("first_fetch", IM_read, 1);
        chk("im_write", IM_write, 0);

        frame(1, 0, 0, 0);
        chk("addi_im", im, 8'h03); chk("addi_ir", ir, 8'h04); chk("addi_alu", alu, 8'h10);
        chk("addi_dm", {de, dr, dw}, 0); chk("addi_rf", rf, 8'h40); chk("addi_pc", pc, 8'h80);
        chk("addi_cyc", cycle_cnt, 8);

        frame(0, 0, 1, 0);
        chk("st_de", de, 8'h20); chk("st_dw", dw, 8'h20); chk("st_dr", dr, 0);
        chk("st_rf", rf, 0); chk("st_pc", pc, 8'h80); chk("st_cyc", cycle_cnt, 16);

        frame(1, 1, 0, 0);
        chk("ld_de", de, 8'h60); chk("ld_dr", dr, 8'h60); chk("ld_dw", dw, 0);
        chk("ld_rf", rf, 8'h80); chk("ld_pc", pc, 8'h80);
        chk("err_before", ctrl_err, 0);

        frame(1, 1, 1, 0);
        chk("ill_err", ctrl_err, 1); chk("ill_dmrf", {de, dr, dw, rf}, 0);
        chk("ill_pc", pc, 8'h80); chk("ill_alu", alu, 8'h10);

        frame(1, 0, 0, 0);
        chk("post_ill_rf", rf, 8'h40); chk("post_ill_pc", pc, 8'h80);
        chk("post_ill_err", ctrl_err, 1); chk("post_ill_cyc", cycle_cnt, 40);
        chk("icnt5", inst_cnt, (icx == 0) ? 128'd0 : 128'd5);

        repeat (16) frame(1, 0, 0, 0);
        chk("pre_halt_cyc", cycle_cnt, 168);
        frame(1, 0, 0, 1);
        chk("halt_im", im, 8'h03); chk("halt_ir", ir, 8'h04);
        chk("halt_late", {alu, de, dr, dw, rf, pc}, 0);
        chk("halted", halted, 1); chk("halt_step", step, 7);
        chk("halt_cyc", cycle_cnt, 176); chk("halt_icnt", inst_cnt, icx);
        repeat (5) @(posedge clk); #1;
        chk("halt_hold", {halted, step}, 4'hf); chk("halt_strb", strb, 0);
        chk("halt_frozen", cycle_cnt, 176);

        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst2_flags", {halted, ctrl_err}, 0);
        reset = 1'b0;
        inst_store = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("st2_step5", step, 5); chk("st2_dw", DM_write, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst3_strb", strb, 0); chk("rst3_step", step, 0); chk("rst3_cyc", cycle_cnt, 0);
        @(posedge clk); #1;
        chk("rst3_dw", DM_write, 0);
        reset = 1'b0; inst_store = 1'b0; #1;
        chk("refetch", {step, IM_read}, 4'h1);
        frame(1, 0, 0, 0);
        chk("re_rf", rf, 8'h40); chk("re_cyc", cycle_cnt, 8);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
